// File: rtl/sdpram_bist_ctrl.sv
// March-less BIST controller for a simple dual-port RAM: fills the array with
// a selectable pattern, reads it back and counts mismatches.
module sdpram_bist_ctrl #(
    parameter int ADDR_WIDTH    = 10,
    parameter int DATA_WIDTH    = 32,
    parameter int RD_LATENCY    = 1,
    parameter int ERR_CNT_WIDTH = 3
) (
    input  logic                     wr_clk,
    input  logic                     tb_wr_rst,
    input  logic                     start,
    input  logic [1:0]               mode,
    output logic                     ram_wr_en,
    output logic [ADDR_WIDTH-1:0]    ram_wr_addr,
    output logic [DATA_WIDTH-1:0]    ram_wr_data,
    output logic                     ram_rd_en,
    output logic [ADDR_WIDTH-1:0]    ram_rd_addr,
    input  logic [DATA_WIDTH-1:0]    ram_rd_data,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic [ERR_CNT_WIDTH-1:0] err_cnt,
    output logic [ADDR_WIDTH-1:0]    first_err_addr
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        GAP,
        READ,
        DRAIN,
        DONE
    } state_t;

    localparam logic [ADDR_WIDTH:0] DEPTH      = (ADDR_WIDTH+1)'(1) << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] CNT_ONE    = (ADDR_WIDTH+1)'(1);
    localparam logic [1:0]          DRAIN_LAST = 2'(RD_LATENCY - 1);

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH:0]     wr_cnt_q, wr_cnt_d;
    logic [ADDR_WIDTH:0]     rd_cnt_q, rd_cnt_d;
    logic [1:0]              drain_q, drain_d;
    logic [1:0]              mode_q, mode_d;
    logic                    start_acc;

    logic [RD_LATENCY-1:0]                 vld_q;
    logic [RD_LATENCY-1:0][DATA_WIDTH-1:0] exp_q;
    logic [RD_LATENCY-1:0][ADDR_WIDTH-1:0] addr_q;

    logic [ERR_CNT_WIDTH-1:0] err_q;
    logic [ADDR_WIDTH-1:0]    first_q;
    logic                     seen_q;
    logic                     mismatch;

    function automatic logic [DATA_WIDTH-1:0] pattern(input logic [1:0] m,
                                                       input logic [ADDR_WIDTH-1:0] a);
        logic [DATA_WIDTH-1:0] chk;
        logic [DATA_WIDTH-1:0] p;
        // Even addresses get ...1010 (0xA..A), odd addresses ...0101.
        for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
            chk[i] = i[0] ^ a[0];
        end
        case (m)
            2'd0:    p = '1 - DATA_WIDTH'(a);
            2'd1:    p = DATA_WIDTH'(a);
            2'd2:    p = chk;
            default: p = ~chk;
        endcase
        return p;
    endfunction

    always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
        if (tb_wr_rst) begin
            state_q  <= IDLE;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            drain_q  <= '0;
            mode_q   <= '0;
        end else begin
            state_q  <= state_d;
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
            drain_q  <= drain_d;
            mode_q   <= mode_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wr_cnt_d  = wr_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        drain_d   = drain_q;
        mode_d    = mode_q;
        start_acc = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    start_acc = 1'b1;
                    mode_d    = mode;
                    wr_cnt_d  = '0;
                    rd_cnt_d  = '0;
                    state_d   = WRITE;
                end
            end
            WRITE: begin
                wr_cnt_d = wr_cnt_q + CNT_ONE;
                if (wr_cnt_d == DEPTH) state_d = GAP;
            end
            GAP: state_d = READ;
            READ: begin
                rd_cnt_d = rd_cnt_q + CNT_ONE;
                if (rd_cnt_d == DEPTH) begin
                    drain_d = '0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                drain_d = drain_q + 2'd1;
                if (drain_q == DRAIN_LAST) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign ram_wr_en   = (state_q == WRITE);
    assign ram_wr_addr = ram_wr_en ? wr_cnt_q[ADDR_WIDTH-1:0] : '0;
    assign ram_wr_data = ram_wr_en ? pattern(mode_q, wr_cnt_q[ADDR_WIDTH-1:0]) : '0;
    assign ram_rd_en   = (state_q == READ);
    assign ram_rd_addr = ram_rd_en ? rd_cnt_q[ADDR_WIDTH-1:0] : '0;

    assign busy = (state_q == WRITE) || (state_q == GAP) ||
                  (state_q == READ)  || (state_q == DRAIN);
    assign done = (state_q == DONE);
    assign pass = done && (err_q == '0);

    assign err_cnt        = err_q;
    assign first_err_addr = first_q;

    // Expected data and address ride alongside the RAM read pipeline so the
    // compare lines up with whatever read latency the RAM has.
    always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
        if (tb_wr_rst) begin
            vld_q  <= '0;
            exp_q  <= '0;
            addr_q <= '0;
        end else begin
            vld_q[0]  <= ram_rd_en;
            exp_q[0]  <= pattern(mode_q, rd_cnt_q[ADDR_WIDTH-1:0]);
            addr_q[0] <= rd_cnt_q[ADDR_WIDTH-1:0];
            for (int unsigned i = 1; i < RD_LATENCY; i++) begin
                vld_q[i]  <= vld_q[i-1];
                exp_q[i]  <= exp_q[i-1];
                addr_q[i] <= addr_q[i-1];
            end
        end
    end

    assign mismatch = vld_q[RD_LATENCY-1] && (ram_rd_data != exp_q[RD_LATENCY-1]);

    always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
        if (tb_wr_rst) begin
            err_q   <= '0;
            first_q <= '0;
            seen_q  <= 1'b0;
        end else if (start_acc) begin
            err_q   <= '0;
            first_q <= '0;
            seen_q  <= 1'b0;
        end else if (mismatch) begin
            if (err_q != '1) err_q <= err_q + ERR_CNT_WIDTH'(1);
            if (!seen_q) begin
                first_q <= addr_q[RD_LATENCY-1];
                seen_q  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sdpram_bist_ctrl.sv
// Directed bench for sdpram_bist_ctrl: two instances (read latency 1 and 2)
// each driving its own behavioural RAM; the latency-1 RAM can inject faults.
module tb_sdpram_bist_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic [1:0] mode;
    int         fault;

    logic       w1_en, r1_en, b1, dn1, p1;
    logic [3:0] w1_a, r1_a, f1;
    logic [7:0] w1_d, r1_d;
    logic [2:0] e1;

    logic       w2_en, r2_en, b2, dn2, p2;
    logic [3:0] w2_a, r2_a, f2;
    logic [7:0] w2_d, r2_d;
    logic [2:0] e2;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] mem1 [16];
    logic [7:0] mem2 [16];
    logic [7:0] q2a;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    sdpram_bist_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .RD_LATENCY(1), .ERR_CNT_WIDTH(3)) dut1 (
        .wr_clk(clk), .tb_wr_rst(rst), .start(start), .mode(mode),
        .ram_wr_en(w1_en), .ram_wr_addr(w1_a), .ram_wr_data(w1_d),
        .ram_rd_en(r1_en), .ram_rd_addr(r1_a), .ram_rd_data(r1_d),
        .busy(b1), .done(dn1), .pass(p1), .err_cnt(e1), .first_err_addr(f1)
    );

    sdpram_bist_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .RD_LATENCY(2), .ERR_CNT_WIDTH(3)) dut2 (
        .wr_clk(clk), .tb_wr_rst(rst), .start(start), .mode(mode),
        .ram_wr_en(w2_en), .ram_wr_addr(w2_a), .ram_wr_data(w2_d),
        .ram_rd_en(r2_en), .ram_rd_addr(r2_a), .ram_rd_data(r2_d),
        .busy(b2), .done(dn2), .pass(p2), .err_cnt(e2), .first_err_addr(f2)
    );

    // fault 1: bit 0 stuck high at address 6; fault 2: read data always zero
    always @(posedge clk) begin
        if (w1_en) mem1[w1_a] <= w1_d;
        if (fault == 2)                    r1_d <= 8'h00;
        else if (fault == 1 && r1_a == 6)  r1_d <= mem1[r1_a] | 8'h01;
        else                               r1_d <= mem1[r1_a];
    end

    always @(posedge clk) begin
        if (w2_en) mem2[w2_a] <= w2_d;
        q2a  <= mem2[r2_a];
        r2_d <= q2a;
    end

    task automatic kick(input logic [1:0] m);
        @(negedge clk);
        mode  = m;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_cycles(input int n, output int d1, output int d2);
        d1 = -1;
        d2 = -1;
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            if (d1 < 0 && dn1) d1 = c;
            if (d2 < 0 && dn2) d2 = c;
        end
    endtask

    task automatic test_reset();
        logic [27:0] v1, v2;
        rst = 1'b1; start = 1'b0; mode = 2'd0; fault = 0;
        repeat (3) @(negedge clk);
        v1 = {b1, dn1, p1, e1, f1, w1_en, w1_a, w1_d, r1_en, r1_a};
        v2 = {b2, dn2, p2, e2, f2, w2_en, w2_a, w2_d, r2_en, r2_a};
        n_cmp++; if (v1 !== '0) begin n_err++; $display("FAIL reset_outs1 got %h want 0", v1); end
        n_cmp++; if (v2 !== '0) begin n_err++; $display("FAIL reset_outs2 got %h want 0", v2); end
        rst = 1'b0;
        repeat (4) @(negedge clk);
        n_cmp++; if ({b1, w1_en, dn1} !== 3'b000) begin n_err++; $display("FAIL post_reset_idle got %b want 000", {b1, w1_en, dn1}); end
    endtask

    task automatic test_mode0();
        int d1, d2;
        logic [3:0] ea;
        logic [7:0] ed;
        d1 = -1; d2 = -1;
        fault = 0;
        kick(2'd0);
        for (int c = 0; c <= 40; c++) begin
            if (c > 0) @(negedge clk);
            if (d1 < 0 && dn1) d1 = c;
            if (d2 < 0 && dn2) d2 = c;
            n_cmp++; if ((w1_en & r1_en) !== 1'b0 || (w2_en & r2_en) !== 1'b0) begin
                n_err++; $display("FAIL wr_rd_excl c=%0d got %b%b/%b%b want no overlap", c, w1_en, r1_en, w2_en, r2_en);
            end
            if (c < 16) begin
                ea = 4'(c);
                ed = 8'hFF - 8'(c);
                n_cmp++; if ({w1_en, w1_a, w1_d} !== {1'b1, ea, ed}) begin
                    n_err++; $display("FAIL write c=%0d got en=%b a=%h d=%h want en=1 a=%h d=%h", c, w1_en, w1_a, w1_d, ea, ed);
                end
            end else if (c == 16) begin
                n_cmp++; if ({w1_en, r1_en, b1} !== 3'b001) begin
                    n_err++; $display("FAIL gap got wen,ren,busy=%b want 001", {w1_en, r1_en, b1});
                end
            end else if (c <= 32) begin
                ea = 4'(c - 17);
                n_cmp++; if ({r1_en, r1_a} !== {1'b1, ea}) begin
                    n_err++; $display("FAIL read c=%0d got en=%b a=%h want en=1 a=%h", c, r1_en, r1_a, ea);
                end
            end
        end
        n_cmp++; if (d1 !== 34) begin n_err++; $display("FAIL done_lat1 got %0d want 34", d1); end
        n_cmp++; if (d2 !== 35) begin n_err++; $display("FAIL done_lat2 got %0d want 35", d2); end
        n_cmp++; if ({p1, e1} !== 4'b1000) begin n_err++; $display("FAIL pass1 got pass=%b err=%0d want 1/0", p1, e1); end
        n_cmp++; if ({p2, e2} !== 4'b1000) begin n_err++; $display("FAIL pass2 got pass=%b err=%0d want 1/0", p2, e2); end
    endtask

    task automatic test_stuck_bit();
        int d1, d2;
        fault = 1;
        kick(2'd2);
        run_cycles(40, d1, d2);
        n_cmp++; if (d1 !== 34) begin n_err++; $display("FAIL stuck_done got %0d want 34", d1); end
        n_cmp++; if (e1 !== 3'd1) begin n_err++; $display("FAIL stuck_err got %0d want 1", e1); end
        n_cmp++; if (f1 !== 4'd6) begin n_err++; $display("FAIL stuck_first got %0d want 6", f1); end
        n_cmp++; if (p1 !== 1'b0) begin n_err++; $display("FAIL stuck_pass got %b want 0", p1); end
    endtask

    task automatic test_saturate_ignore();
        int d1, d2;
        fault = 2;
        kick(2'd1);
        d1 = -1; d2 = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (d1 < 0 && dn1) d1 = c;
            if (d2 < 0 && dn2) d2 = c;
            if (c == 20) begin mode = 2'd3; start = 1'b1; end
            if (c == 21) start = 1'b0;
        end
        n_cmp++; if (d1 !== 34) begin n_err++; $display("FAIL ign_read_done got %0d want 34", d1); end
        n_cmp++; if (e1 !== 3'd7) begin n_err++; $display("FAIL sat_err got %0d want 7", e1); end
        n_cmp++; if (f1 !== 4'd1) begin n_err++; $display("FAIL sat_first got %0d want 1", f1); end
        n_cmp++; if (p1 !== 1'b0) begin n_err++; $display("FAIL sat_pass got %b want 0", p1); end
    endtask

    task automatic test_back_to_back();
        int d1;
        fault = 0;
        kick(2'd0);
        n_cmp++; if ({dn1, b1, e1, f1} !== {1'b0, 1'b1, 3'd0, 4'd0}) begin
            n_err++; $display("FAIL restart_clear got done=%b busy=%b err=%0d first=%0d want 0 1 0 0", dn1, b1, e1, f1);
        end
        d1 = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (d1 < 0 && dn1) d1 = c;
            if (c == 33) start = 1'b1;
            if (c == 34) start = 1'b0;
            if (c == 36) begin
                n_cmp++; if ({b1, dn1} !== 2'b01) begin
                    n_err++; $display("FAIL start_at_done_entry got busy,done=%b want 01", {b1, dn1});
                end
            end
        end
        n_cmp++; if (d1 !== 34) begin n_err++; $display("FAIL b2b_done got %0d want 34", d1); end
        n_cmp++; if ({p1, e1} !== 4'b1000) begin n_err++; $display("FAIL b2b_pass got pass=%b err=%0d want 1/0", p1, e1); end
    endtask

    task automatic test_reset_midrun();
        logic [27:0] v1, v2;
        fault = 0;
        kick(2'd1);
        repeat (4) @(negedge clk);
        n_cmp++; if ({w1_en, w1_a} !== 5'b1_0100) begin n_err++; $display("FAIL midrun_pre got en=%b a=%h want 1/4", w1_en, w1_a); end
        rst = 1'b1;
        #1;
        v1 = {b1, dn1, p1, e1, f1, w1_en, w1_a, w1_d, r1_en, r1_a};
        v2 = {b2, dn2, p2, e2, f2, w2_en, w2_a, w2_d, r2_en, r2_a};
        n_cmp++; if (v1 !== '0) begin n_err++; $display("FAIL midrun_outs1 got %h want 0", v1); end
        n_cmp++; if (v2 !== '0) begin n_err++; $display("FAIL midrun_outs2 got %h want 0", v2); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            n_cmp++; if ({w1_en, w2_en, b1, b2} !== 4'b0000) begin
                n_err++; $display("FAIL midrun_nowrite c=%0d got %b want 0000", c, {w1_en, w2_en, b1, b2});
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mode = 2'd0; fault = 0;
        test_reset();
        test_mode0();
        test_stuck_bit();
        test_saturate_ignore();
        test_back_to_back();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sdpram_bist_ctrl.md
SDPRAM_BIST_CTRL -- requirements
Module: sdpram_bist_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, RAM address width; depth N = 2**ADDR_WIDTH, legal range 4..20.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, RAM data width, legal range 1..1152.
REQ-003 SHALL have parameter RD_LATENCY, default 1, RAM read latency in cycles (1 = no output register, 2 = output register), legal values 1 and 2 only.
REQ-004 SHALL have parameter ERR_CNT_WIDTH, default 3, width of the error counter.
REQ-005 SHALL have port wr_clk, input, 1 bit, the single clock for the controller and both RAM ports.
REQ-006 SHALL have port tb_wr_rst, input, 1 bit, reset: asynchronous, active-high, clock wr_clk.
REQ-007 SHALL have port start, input, 1 bit, run request pulse.
REQ-008 SHALL have port mode, input, 2 bits, pattern select, sampled on an accepted start.
REQ-009 SHALL have port ram_wr_en, output, 1 bit, RAM write enable.
REQ-010 SHALL have port ram_wr_addr, output, ADDR_WIDTH bits, RAM write address.
REQ-011 SHALL have port ram_wr_data, output, DATA_WIDTH bits, RAM write data.
REQ-012 SHALL have port ram_rd_en, output, 1 bit, read-phase indicator.
REQ-013 SHALL have port ram_rd_addr, output, ADDR_WIDTH bits, RAM read address.
REQ-014 SHALL have port ram_rd_data, input, DATA_WIDTH bits, RAM read data.
REQ-015 SHALL have port busy, output, 1 bit, run in progress.
REQ-016 SHALL have port done, output, 1 bit, run complete; held until the next accepted start.
REQ-017 SHALL have port pass, output, 1 bit, valid while done=1; pass=1 when err_cnt=0.
REQ-018 SHALL have port err_cnt, output, ERR_CNT_WIDTH bits, saturating mismatch count.
REQ-019 SHALL have port first_err_addr, output, ADDR_WIDTH bits, read address of the first mismatch.

Function
REQ-020 SHALL implement FSM states IDLE, WRITE, GAP, READ, DRAIN and DONE.
REQ-021 SHALL accept start only in IDLE or DONE, moving to WRITE on the next edge; start SHALL be ignored in every other state.
REQ-022 An accepted start SHALL latch mode and SHALL clear done, err_cnt, first_err_addr and the first-error flag.
REQ-023 WRITE SHALL last exactly N cycles: ram_wr_en=1 and ram_wr_addr=0..N-1, one address per cycle.
REQ-024 GAP SHALL last exactly 1 cycle with ram_wr_en=0 and ram_rd_en=0.
REQ-025 READ SHALL last exactly N cycles: ram_rd_en=1 and ram_rd_addr=0..N-1, one address per cycle.
REQ-026 DRAIN SHALL last exactly RD_LATENCY cycles, after which the FSM SHALL enter DONE.
REQ-027 From an accepted start, done SHALL rise exactly 2N+1+RD_LATENCY+1 edges later.
REQ-028 Pattern for address a, mode 0: all-ones minus a (decrementing count).
REQ-029 Pattern for address a, mode 1: a zero-extended or truncated to DATA_WIDTH.
REQ-030 Pattern for address a, mode 2: checkerboard, 0xA..A for even a and 0x5..5 for odd a.
REQ-031 Pattern for address a, mode 3: the complement of mode 2.
REQ-032 Expected data and the read address SHALL travel through a valid-tagged pipeline of depth RD_LATENCY.
REQ-033 ram_rd_data SHALL be compared against the expected data on every cycle where the pipeline-output valid bit is 1.
REQ-034 Each mismatch SHALL increment err_cnt; err_cnt SHALL saturate at all-ones and never wrap.
REQ-035 On the first mismatch of a run, first_err_addr SHALL capture the delayed read address; later mismatches SHALL not change it.
REQ-036 busy SHALL be 1 in WRITE, GAP, READ and DRAIN, and 0 otherwise.
REQ-037 ram_wr_en and ram_rd_en SHALL never both be 1 in the same cycle.
REQ-038 The address counters SHALL be ADDR_WIDTH+1 bits wide; the terminal count is reached when the counter equals N.
REQ-039 A start arriving in the same cycle as DONE entry SHALL be ignored.

Reset
REQ-040 While tb_wr_rst=1, the FSM SHALL be in IDLE and all outputs SHALL be 0, with the pipeline valid bits cleared.
REQ-041 Reset asserted mid-run SHALL abort the run immediately with no further RAM accesses.
REQ-042 After reset release, the block SHALL stay in IDLE until start.

Verification (ADDR_WIDTH=4, DATA_WIDTH=8)
REQ-043 Run with a behavioural RAM model, mode 0, RD_LATENCY=1: writes 0xFF..0xF0 to addresses 0..15; done rises 34 cycles after start; pass=1, err_cnt=0.
REQ-044 Same run with RD_LATENCY=2 and a registered RAM model: done rises 35 cycles after start; pass=1.
REQ-045 Mode 2 run with a model whose bit 0 is stuck at 1 at address 6: err_cnt=1, first_err_addr=6, pass=0.
REQ-046 Mode 1 run with a model that always returns 0x00 and ERR_CNT_WIDTH=3: err_cnt saturates at 7; first_err_addr=1.
REQ-047 start pulsed during READ, then a fresh start in DONE: the pulse during READ is ignored and the second run clears err_cnt and done.
REQ-048 tb_wr_rst asserted at the 5th WRITE cycle: all outputs go to 0 immediately, and no further writes occur.
